// File: rtl/axi4lite_req_arbiter.sv
// Two-requester round-robin front end for an AXI4-Lite master: one command in flight,
// per-command timeout that answers with SLVERR when the master never completes.
module axi4lite_req_arbiter #(
    parameter int ADDRWIDTH = 32,
    parameter int DATAWIDTH = 32,
    parameter int TIMEOUT   = 16
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic                 req0_valid,
    input  logic                 req0_write,
    input  logic [ADDRWIDTH-1:0] req0_addr,
    input  logic [DATAWIDTH-1:0] req0_wdata,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic                 req1_write,
    input  logic [ADDRWIDTH-1:0] req1_addr,
    input  logic [DATAWIDTH-1:0] req1_wdata,
    output logic                 req1_ready,
    output logic                 rsp0_valid,
    output logic                 rsp1_valid,
    output logic [DATAWIDTH-1:0] rsp_rdata,
    output logic [1:0]           rsp_resp,
    output logic                 mst_rd_en,
    output logic                 mst_wr_en,
    output logic [ADDRWIDTH-1:0] mst_raddr,
    output logic [ADDRWIDTH-1:0] mst_waddr,
    output logic [DATAWIDTH-1:0] mst_wdata,
    input  logic                 mst_rd_done,
    input  logic                 mst_wr_done,
    input  logic [DATAWIDTH-1:0] mst_rdata,
    input  logic [1:0]           mst_resp
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
    localparam logic [1:0] SLVERR    = 2'b10;

    state_t                 state;
    logic                   last_gnt;
    logic                   cur_id;
    logic                   cur_write;
    logic [7:0]             wait_cnt;
    logic                   grant0;
    logic                   grant1;
    logic                   done_match;
    logic                   sel_write;
    logic [ADDRWIDTH-1:0]   sel_addr;
    logic [DATAWIDTH-1:0]   sel_wdata;

    // last_gnt = 1 means req1 was served last, so req0 now has priority
    always_comb begin
        grant0     = req0_valid && (!req1_valid || last_gnt);
        grant1     = req1_valid && !grant0;
        sel_write  = grant1 ? req1_write : req0_write;
        sel_addr   = grant1 ? req1_addr  : req0_addr;
        sel_wdata  = grant1 ? req1_wdata : req0_wdata;
        done_match = cur_write ? mst_wr_done : mst_rd_done;
    end

    assign req0_ready = !ARESET && (state == IDLE) && grant0;
    assign req1_ready = !ARESET && (state == IDLE) && grant1;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state      <= IDLE;
            last_gnt   <= 1'b1;
            cur_id     <= 1'b0;
            cur_write  <= 1'b0;
            wait_cnt   <= 8'd0;
            mst_rd_en  <= 1'b0;
            mst_wr_en  <= 1'b0;
            mst_raddr  <= '0;
            mst_waddr  <= '0;
            mst_wdata  <= '0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp_rdata  <= '0;
            rsp_resp   <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        cur_id    <= grant1;
                        cur_write <= sel_write;
                        if (sel_write) begin
                            mst_wr_en <= 1'b1;
                            mst_waddr <= sel_addr;
                            mst_wdata <= sel_wdata;
                        end else begin
                            mst_rd_en <= 1'b1;
                            mst_raddr <= sel_addr;
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    mst_rd_en <= 1'b0;
                    mst_wr_en <= 1'b0;
                    wait_cnt  <= 8'd0;
                    state     <= WAIT;
                end
                WAIT: begin
                    // a matching done in the final wait cycle wins over the timeout
                    if (done_match) begin
                        rsp_resp   <= mst_resp;
                        rsp_rdata  <= cur_write ? '0 : mst_rdata;
                        rsp0_valid <= !cur_id;
                        rsp1_valid <= cur_id;
                        state      <= RESP;
                    end else if (wait_cnt == WAIT_LAST) begin
                        rsp_resp   <= SLVERR;
                        rsp_rdata  <= '0;
                        rsp0_valid <= !cur_id;
                        rsp1_valid <= cur_id;
                        state      <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                RESP: begin
                    rsp0_valid <= 1'b0;
                    rsp1_valid <= 1'b0;
                    last_gnt   <= cur_id;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi4lite_req_arbiter.sv
// Bench for axi4lite_req_arbiter: transaction-timeline reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic and dones.
module tb_axi4lite_req_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic req0_valid = 0, req0_write = 0, req1_valid = 0, req1_write = 0;
    logic [AW-1:0] req0_addr = '0, req1_addr = '0;
    logic [DW-1:0] req0_wdata = '0, req1_wdata = '0;
    logic req0_ready, req1_ready, rsp0_valid, rsp1_valid, mst_rd_en, mst_wr_en;
    logic [DW-1:0] rsp_rdata, mst_wdata;
    logic [1:0] rsp_resp;
    logic [AW-1:0] mst_raddr, mst_waddr;
    logic mst_rd_done = 0, mst_wr_done = 0;
    logic [DW-1:0] mst_rdata = '0;
    logic [1:0] mst_resp = 2'b00;

    axi4lite_req_arbiter #(.ADDRWIDTH(AW), .DATAWIDTH(DW), .TIMEOUT(TO)) dut (
        .ACLK(clk), .ARESET(rst),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .mst_rd_en(mst_rd_en), .mst_wr_en(mst_wr_en),
        .mst_raddr(mst_raddr), .mst_waddr(mst_waddr), .mst_wdata(mst_wdata),
        .mst_rd_done(mst_rd_done), .mst_wr_done(mst_wr_done),
        .mst_rdata(mst_rdata), .mst_resp(mst_resp)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int grant_log[$];
    bit auto_mode = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: one transaction timeline (accept cycle, response cycle) per command
    bit m_busy = 0, m_last = 1, m_id = 0, m_wr = 0;
    int m_acc = 0, m_rsp_cyc = -1;
    logic [AW-1:0] m_raddr = '0, m_waddr = '0;
    logic [DW-1:0] m_wdata = '0, m_rdata = '0;
    logic [1:0] m_resp = 2'b00;
    bit e_r0, e_r1, e_rd, e_wr, e_v0, e_v1;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                m_busy = 0; m_last = 1; m_rsp_cyc = -1;
                m_raddr = '0; m_waddr = '0; m_wdata = '0; m_rdata = '0; m_resp = 2'b00;
                {e_r0, e_r1, e_rd, e_wr, e_v0, e_v1} = '0;
            end else begin
                e_r0 = !m_busy && req0_valid && (!req1_valid || m_last);
                e_r1 = !m_busy && req1_valid && !e_r0;
                e_rd = m_busy && (cyc == m_acc + 1) && !m_wr;
                e_wr = m_busy && (cyc == m_acc + 1) && m_wr;
                e_v0 = m_busy && (m_rsp_cyc == cyc) && !m_id;
                e_v1 = m_busy && (m_rsp_cyc == cyc) && m_id;
            end
            chk("req0_ready", 64'(req0_ready), 64'(e_r0));
            chk("req1_ready", 64'(req1_ready), 64'(e_r1));
            chk("no_double_ready", 64'(req0_ready & req1_ready), 64'd0);
            chk("mst_rd_en", 64'(mst_rd_en), 64'(e_rd));
            chk("mst_wr_en", 64'(mst_wr_en), 64'(e_wr));
            chk("rsp0_valid", 64'(rsp0_valid), 64'(e_v0));
            chk("rsp1_valid", 64'(rsp1_valid), 64'(e_v1));
            chk("mst_raddr", 64'(mst_raddr), 64'(m_raddr));
            chk("mst_waddr", 64'(mst_waddr), 64'(m_waddr));
            chk("mst_wdata", 64'(mst_wdata), 64'(m_wdata));
            chk("rsp_rdata", 64'(rsp_rdata), 64'(m_rdata));
            chk("rsp_resp", 64'(rsp_resp), 64'(m_resp));
            if (req0_ready) grant_log.push_back(0);
            if (req1_ready) grant_log.push_back(1);
            if (!rst) begin
                if (m_busy) begin
                    if (m_rsp_cyc == cyc) begin
                        m_busy = 0;
                        m_last = m_id;
                    end else if (m_rsp_cyc < 0 && cyc >= m_acc + 2) begin
                        if (m_wr ? mst_wr_done : mst_rd_done) begin
                            m_rsp_cyc = cyc + 1;
                            m_resp = mst_resp;
                            m_rdata = m_wr ? '0 : mst_rdata;
                        end else if (cyc == m_acc + 1 + TO) begin
                            m_rsp_cyc = cyc + 1;
                            m_resp = 2'b10;
                            m_rdata = '0;
                        end
                    end
                end else if (e_r0 || e_r1) begin
                    m_busy = 1; m_acc = cyc; m_id = e_r1; m_rsp_cyc = -1;
                    m_wr = e_r1 ? req1_write : req0_write;
                    if (m_wr) begin
                        m_waddr = e_r1 ? req1_addr : req0_addr;
                        m_wdata = e_r1 ? req1_wdata : req0_wdata;
                    end else begin
                        m_raddr = e_r1 ? req1_addr : req0_addr;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (auto_mode) begin
            mst_rd_done = ($urandom_range(0, 99) < 30);
            mst_wr_done = ($urandom_range(0, 99) < 30);
            mst_rdata = $urandom;
            mst_resp = 2'($urandom_range(0, 3));
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #1 rst = 1'b1;
        ticks(2);
        @(negedge clk);
        chk("reset_ctl", 64'({req0_ready, req1_ready, rsp0_valid, rsp1_valid, mst_rd_en, mst_wr_en, rsp_resp}), 64'd0);
        chk("reset_raddr", 64'(mst_raddr), 64'd0);
        tick();
        rst = 1'b0;
        ticks(2);

        // single read from req0
        tick();
        req0_valid = 1; req0_write = 0; req0_addr = 32'h10;
        @(negedge clk); chk("rd_accept", 64'(req0_ready), 64'd1);
        tick();
        req0_valid = 0;
        @(negedge clk); chk("rd_en_T1", 64'({mst_rd_en, mst_wr_en}), 64'b10);
        chk("rd_addr_T1", 64'(mst_raddr), 64'h10);
        ticks(3);
        mst_rd_done = 1; mst_rdata = 32'hDEADBEEF; mst_resp = 2'b00;
        tick();
        mst_rd_done = 0; mst_rdata = '0;
        @(negedge clk); chk("rd_rsp_T5", 64'({rsp0_valid, rsp1_valid}), 64'b10);
        chk("rd_rdata", 64'(rsp_rdata), 64'hDEADBEEF);
        chk("rd_resp", 64'(rsp_resp), 64'd0);
        tick();

        // timeout on a req1 read: response after exactly TO wait cycles
        tick();
        req1_valid = 1; req1_write = 0; req1_addr = 32'h20;
        @(negedge clk); chk("to_accept", 64'({req0_ready, req1_ready}), 64'b01);
        tick();
        req1_valid = 0;
        ticks(4);
        @(negedge clk); chk("to_not_early", 64'(rsp1_valid), 64'd0);
        tick();
        @(negedge clk); chk("to_rsp", 64'(rsp1_valid), 64'd1);
        chk("to_resp", 64'(rsp_resp), 64'b10);
        chk("to_rdata", 64'(rsp_rdata), 64'd0);
        tick();

        // contention: both requesters hold valid, grants must alternate starting with req0
        grant_log.delete();
        auto_mode = 1;
        tick();
        req0_valid = 1; req0_write = 1; req0_addr = 32'h0; req0_wdata = 32'h1111;
        req1_valid = 1; req1_write = 1; req1_addr = 32'h4; req1_wdata = 32'h2222;
        ticks(30);
        req0_valid = 0; req1_valid = 0;
        auto_mode = 0; mst_rd_done = 0; mst_wr_done = 0;
        ticks(10);
        chk("cont_grants_ge4", 64'(grant_log.size() >= 4), 64'd1);
        for (int i = 0; i < 4; i++)
            if (i < grant_log.size()) chk("cont_grant_order", 64'(grant_log[i]), 64'(i % 2));

        // wrong-type done during a write is ignored
        tick();
        req0_valid = 1; req0_write = 1; req0_addr = 32'h30; req0_wdata = 32'hA5A5;
        @(negedge clk); chk("wt_accept", 64'(req0_ready), 64'd1);
        tick();
        req0_valid = 0;
        @(negedge clk); chk("wt_wr_en", 64'({mst_rd_en, mst_wr_en}), 64'b01);
        chk("wt_waddr", 64'(mst_waddr), 64'h30);
        tick();
        mst_rd_done = 1; mst_resp = 2'b11;
        tick();
        mst_rd_done = 0;
        @(negedge clk); chk("wt_ignored", 64'(rsp0_valid), 64'd0);
        tick();
        mst_wr_done = 1; mst_resp = 2'b01; mst_rdata = 32'h1234;
        tick();
        mst_wr_done = 0; mst_rdata = '0; mst_resp = 2'b00;
        @(negedge clk); chk("wt_rsp", 64'(rsp0_valid), 64'd1);
        chk("wt_resp", 64'(rsp_resp), 64'b01);
        chk("wt_rdata_zero", 64'(rsp_rdata), 64'd0);
        tick();

        // reset in WAIT, late done afterwards, then req0 wins first again
        tick();
        req0_valid = 1; req0_write = 0; req0_addr = 32'h40;
        tick();
        req0_valid = 0;
        ticks(2);
        rst = 1;
        @(negedge clk);
        chk("mid_rst_ctl", 64'({req0_ready, req1_ready, rsp0_valid, rsp1_valid, mst_rd_en, mst_wr_en, rsp_resp}), 64'd0);
        chk("mid_rst_addr", 64'(mst_raddr | mst_waddr | mst_wdata | rsp_rdata), 64'd0);
        ticks(2);
        rst = 0;
        tick();
        mst_rd_done = 1; mst_rdata = 32'hBAD0BAD0;
        tick();
        mst_rd_done = 0; mst_rdata = '0;
        @(negedge clk); chk("late_done_ignored", 64'({rsp0_valid, rsp1_valid}), 64'd0);
        tick();
        req0_valid = 1; req1_valid = 1; req0_write = 0; req1_write = 0;
        @(negedge clk); chk("post_rst_req0_first", 64'({req0_ready, req1_ready}), 64'b10);
        tick();
        req0_valid = 0; req1_valid = 0;
        auto_mode = 1;
        ticks(20);

        // randomized traffic, dones and occasional resets
        for (int i = 0; i < 3000; i++) begin
            tick();
            rst = ($urandom_range(0, 199) == 0);
            req0_valid = ($urandom_range(0, 99) < 50);
            req1_valid = ($urandom_range(0, 99) < 50);
            req0_write = $urandom_range(0, 1) == 1;
            req1_write = $urandom_range(0, 1) == 1;
            req0_addr = $urandom; req1_addr = $urandom;
            req0_wdata = $urandom; req1_wdata = $urandom;
        end
        rst = 0; req0_valid = 0; req1_valid = 0;
        ticks(10);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
